// File: rtl/bcd_key_entry_display_pkg.sv
// Shared types and constants for the keypad BCD entry and 7-segment display block.
package bcd_key_entry_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment bit0=a .. bit6=g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_key_entry_display_bcd_to_7seg.sv
// Combinational BCD digit to 7-segment pattern; non-BCD codes render blank.
module bcd_to_7seg
    import bcd_key_entry_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_key_entry_display.sv
// Debounced keypad digit entry into a BCD shift register, shown on a scanned
// 7-segment display with leading-zero blanking.
module bcd_key_entry_display
    import bcd_key_entry_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [3:0]                        bcd_in,
    input  logic                              key_down,
    input  logic                              clear,
    output logic [4*NUM_DIGITS-1:0]           value_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
    output logic                              entry_pulse,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an
);

    localparam int CW = $clog2(NUM_DIGITS+1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    key_state_t    state, state_next;
    logic [DW-1:0] db_cnt, db_cnt_next;
    logic          accept;

    logic [PW-1:0] prescale;
    logic [IW-1:0] scan_idx;
    logic [3:0]    sel_digit;
    logic [6:0]    dec_seg;
    logic          blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    // The edge that leaves IDLE/HELD is the first sample of a run, so the
    // run completes when the counter has already seen DEBOUNCE_CYCLES-2 more.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (key_down) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_down) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DW'(DEBOUNCE_CYCLES-2)) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                    accept      = 1'b1;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!key_down) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_down) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end else if (db_cnt == DW'(DEBOUNCE_CYCLES-2)) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_out   <= '0;
            digit_count <= '0;
            entry_pulse <= 1'b0;
        end else if (clear) begin
            value_out   <= '0;
            digit_count <= '0;
            entry_pulse <= 1'b0;
        end else if (accept && (bcd_in <= BCD_MAX)) begin
            value_out   <= {value_out[4*NUM_DIGITS-5:0], bcd_in};
            if (digit_count != CW'(NUM_DIGITS))
                digit_count <= digit_count + 1'b1;
            entry_pulse <= 1'b1;
        end else begin
            entry_pulse <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            scan_idx <= '0;
        end else if (prescale == PW'(SCAN_DIV-1)) begin
            prescale <= '0;
            scan_idx <= (scan_idx == IW'(NUM_DIGITS-1)) ? '0 : scan_idx + 1'b1;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    assign sel_digit = value_out[4*scan_idx +: 4];
    assign blank     = (int'(scan_idx) >= int'(digit_count)) && (scan_idx != '0);

    bcd_to_7seg u_dec (
        .bcd (sel_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_0;
            an  <= NUM_DIGITS'(1);
        end else begin
            seg <= blank ? SEG_BLANK : dec_seg;
            an  <= NUM_DIGITS'(1) << scan_idx;
        end
    end

endmodule

// File: tb/tb_bcd_key_entry_display.sv
// Directed and randomized bench for bcd_key_entry_display against a run-length debounce model.
module tb_bcd_key_entry_display;

    localparam int N = 4;
    localparam int D = 4;
    localparam int S = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    bcd_in = 4'd0;
    logic          key_down = 1'b0;
    logic          clear = 1'b0;
    logic [4*N-1:0] value_out;
    logic [2:0]    digit_count;
    logic          entry_pulse;
    logic [6:0]    seg;
    logic [N-1:0]  an;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: debounced level flips after D consecutive samples that differ from it.
    logic [15:0] m_val;
    int          m_cnt;
    bit          m_deb;
    int          m_run;
    bit          m_pulse;
    int          m_k;

    always #5 clk = ~clk;

    bcd_key_entry_display #(
        .NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .SCAN_DIV(S)
    ) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .key_down(key_down), .clear(clear),
        .value_out(value_out), .digit_count(digit_count), .entry_pulse(entry_pulse),
        .seg(seg), .an(an)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit key);
        rst = 1'b1; key_down = key; clear = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_val = '0; m_cnt = 0; m_deb = 0; m_run = 0; m_pulse = 0; m_k = 0;
        chk("rst_value", value_out, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_pulse", entry_pulse, 0);
        chk("rst_an", an, 1);
        chk("rst_seg", seg, 7'h3F);
    endtask

    task automatic step(input bit key, input logic [3:0] b, input bit clr);
        int idx;
        logic [3:0] d;
        logic [6:0] es;
        logic [N-1:0] ea;
        bit acc;
        key_down = key; bcd_in = b; clear = clr;
        idx = (m_k / S) % N;
        d   = m_val[4*idx +: 4];
        es  = (idx >= m_cnt && idx != 0) ? 7'h00 : seg_tab[d];
        ea  = N'(1 << idx);
        acc = 0;
        if (key != m_deb) begin
            m_run++;
            if (m_run == D) begin
                m_deb = key; m_run = 0; acc = key;
            end
        end else begin
            m_run = 0;
        end
        if (clr) begin
            m_val = '0; m_cnt = 0; m_pulse = 0;
        end else if (acc && b <= 9) begin
            m_val = m_val * 16 + b;
            m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
            m_pulse = 1;
        end else begin
            m_pulse = 0;
        end
        m_k++;
        @(posedge clk); #1;
        if (entry_pulse === 1'b1) pulses++;
        chk("value", value_out, m_val);
        chk("count", digit_count, m_cnt);
        chk("pulse", entry_pulse, m_pulse);
        chk("seg", seg, es);
        chk("an", an, ea);
    endtask

    task automatic press(input logic [3:0] b);
        for (int i = 0; i < D + 2; i++) step(1, b, 0);
        for (int i = 0; i < D + 2; i++) step(0, b, 0);
    endtask

    initial begin
        bit lvl;
        int len;
        logic [3:0] rb;

        do_reset(0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        pulses = 0;
        for (int i = 0; i < 10; i++) step(1, 5, 0);
        for (int i = 0; i < 10; i++) step(0, 5, 0);
        chk("one_pulse_5", pulses, 1);
        chk("val_5", value_out, 16'h0005);
        chk("cnt_5", digit_count, 1);

        pulses = 0;
        for (int i = 0; i < 3; i++) step(1, 7, 0);
        step(0, 7, 0);
        for (int i = 0; i < 2; i++) step(1, 7, 0);
        for (int i = 0; i < 6; i++) step(0, 7, 0);
        chk("bounce_no_pulse", pulses, 0);
        chk("bounce_val", value_out, 16'h0005);

        for (int i = 1; i <= 5; i++) press(4'(i));
        chk("full_val", value_out, 16'h2345);
        chk("full_cnt", digit_count, 4);
        for (int i = 0; i < 16; i++) step(0, 0, 0);

        pulses = 0;
        press(4'hC);
        chk("nonbcd_no_pulse", pulses, 0);
        chk("nonbcd_val", value_out, 16'h2345);

        for (int i = 0; i < D + 2; i++) step(1, 8, (i == D - 1));
        for (int i = 0; i < D + 2; i++) step(0, 8, 0);
        chk("clear_no_pulse", pulses, 0);
        chk("clear_val", value_out, 0);
        chk("clear_cnt", digit_count, 0);

        for (int i = 0; i < 2; i++) step(1, 6, 0);
        do_reset(1);
        pulses = 0;
        for (int i = 0; i < D - 1; i++) step(1, 6, 0);
        chk("rst_mid_wait", pulses, 0);
        step(1, 6, 0);
        chk("rst_mid_accept", pulses, 1);
        for (int i = 0; i < D + 2; i++) step(0, 6, 0);

        lvl = 1;
        for (int r = 0; r < 80; r++) begin
            len = $urandom_range(1, 7);
            rb = 4'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) step(lvl, rb, ($urandom_range(0, 19) == 0));
            lvl = !lvl;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
